// File: rtl/tt_sel_seq_pkg.sv
// Shared types for the select sequencer: state encoding, select width, phase timer width.
// The controller uses SEL_W as well, so the two always agree on the counter width.
package tt_sel_seq_pkg;

    localparam int SEL_W = 10;
    localparam int TMR_W = 8;

    typedef logic [TMR_W-1:0] tmr_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DIS    = 3'd1;
    localparam logic [2:0] ST_RST    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_INC_HI = 3'd4;
    localparam logic [2:0] ST_INC_LO = 3'd5;
    localparam logic [2:0] ST_SETTLE = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    // A phase lasting n cycles loads n-1, so the timer reads zero in its last cycle.
    function automatic tmr_t phase_len(input int cycles);
        return tmr_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/tt_sel_seq_if.sv
// Request/completion bundle between the address requester and the select sequencer.
// master drives the request; slave answers with ready, the done pulse and the shadow select.
interface tt_sel_seq_if
    import tt_sel_seq_pkg::*;
#(
    parameter int SEL_W = tt_sel_seq_pkg::SEL_W
);
    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_addr;
    logic             req_ena;
    logic             req_force;
    logic             done;
    logic [SEL_W-1:0] cur_sel;

    modport master (
        output req_valid, req_addr, req_ena, req_force,
        input  req_ready, done, cur_sel
    );

    modport slave (
        input  req_valid, req_addr, req_ena, req_force,
        output req_ready, done, cur_sel
    );
endinterface

// File: rtl/tt_sel_seq_timer.sv
// Loadable down-counter timing every sequencer phase; zero flags the last cycle of a phase.
// Load takes effect on the next edge; the count holds at zero until reloaded.
module tt_sel_seq_timer
    import tt_sel_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  tmr_t load_val,
    output logic zero
);

    tmr_t cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - tmr_t'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sel_seq.sv
// Turns a target design address into reset/increment pulses for the controller's ripple select counter.
// Latency 1 + [RST_CYC+INC_LO] + n*(INC_HI+INC_LO) + SETTLE + 1 cycles; req_ready is high only in IDLE.
module tt_sel_seq
    import tt_sel_seq_pkg::*;
#(
    parameter int SEL_W   = tt_sel_seq_pkg::SEL_W,
    parameter int RST_CYC = 2,
    parameter int INC_HI  = 2,
    parameter int INC_LO  = 2,
    parameter int SETTLE  = 4
)(
    input  logic         clk,
    input  logic         rst_n,
    tt_sel_seq_if.slave  req,
    output logic         ctrl_sel_rst_n,
    output logic         ctrl_sel_inc,
    output logic         ctrl_ena
);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [SEL_W-1:0] addr_q;
    logic             ena_q;
    logic             frc_q;
    logic [SEL_W-1:0] remaining;
    logic [SEL_W-1:0] cur_sel_q;
    logic             done_q;
    logic             tmr_zero;
    logic             tmr_load;
    tmr_t             tmr_val;
    logic             use_rst;

    // A lower target can only be reached through reset: the counter is never wrapped.
    assign use_rst = frc_q || (addr_q < cur_sel_q);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (req.req_valid) nxt = ST_DIS;
            ST_DIS: begin
                if (use_rst)                   nxt = ST_RST;
                else if (addr_q == cur_sel_q)  nxt = ST_SETTLE;
                else                           nxt = ST_INC_HI;
            end
            ST_RST:    if (tmr_zero) nxt = ST_GAP;
            ST_GAP:    if (tmr_zero) nxt = (remaining != '0) ? ST_INC_HI : ST_SETTLE;
            ST_INC_HI: if (tmr_zero) nxt = ST_INC_LO;
            ST_INC_LO: if (tmr_zero) nxt = (remaining != '0) ? ST_INC_HI : ST_SETTLE;
            ST_SETTLE: if (tmr_zero) nxt = ST_DONE;
            ST_DONE:   nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_load = (nxt != state);
        case (nxt)
            ST_RST:    tmr_val = phase_len(RST_CYC);
            ST_GAP:    tmr_val = phase_len(INC_LO);
            ST_INC_HI: tmr_val = phase_len(INC_HI);
            ST_INC_LO: tmr_val = phase_len(INC_LO);
            ST_SETTLE: tmr_val = phase_len(SETTLE);
            default:   tmr_val = '0;
        endcase
    end

    tt_sel_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            ena_q     <= 1'b0;
            frc_q     <= 1'b0;
            remaining <= '0;
        end else begin
            state <= nxt;
            if (state == ST_IDLE && req.req_valid) begin
                addr_q <= req.req_addr;
                ena_q  <= req.req_ena;
                frc_q  <= req.req_force;
            end
            if (state == ST_DIS) begin
                remaining <= use_rst ? addr_q : (addr_q - cur_sel_q);
            end else if (state == ST_INC_HI && nxt == ST_INC_LO) begin
                remaining <= remaining - SEL_W'(1);
            end
        end
    end

    // Control outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            done_q         <= 1'b0;
            cur_sel_q      <= '0;
        end else begin
            ctrl_sel_rst_n <= (nxt != ST_RST);
            ctrl_sel_inc   <= (nxt == ST_INC_HI);
            done_q         <= (nxt == ST_DONE);
            if (nxt == ST_DONE) begin
                ctrl_ena  <= ena_q;
                cur_sel_q <= addr_q;
            end else if (nxt != ST_IDLE) begin
                ctrl_ena  <= 1'b0;
            end
        end
    end

    assign req.req_ready = (state == ST_IDLE);
    assign req.done      = done_q;
    assign req.cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_tt_sel_seq.sv
// Randomised scoreboard bench for tt_sel_seq: expectations come from the latency/pulse-count rules
// and a bench-side ripple counter fed by the DUT's control lines.
module tb_tt_sel_seq;
    import tt_sel_seq_pkg::*;

    localparam int RST_CYC = 2;
    localparam int INC_HI  = 2;
    localparam int INC_LO  = 2;
    localparam int SETTLE  = 4;
    localparam int CNT_MOD = 1 << SEL_W;

    typedef struct {
        int addr;
        int ena;
        int lat;
        int rst_lo;
        int pulses;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;

    tt_sel_seq_if #(.SEL_W(SEL_W)) bus ();

    tt_sel_seq #(
        .SEL_W   (SEL_W),
        .RST_CYC (RST_CYC),
        .INC_HI  (INC_HI),
        .INC_LO  (INC_LO),
        .SETTLE  (SETTLE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (bus.slave),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   sh = 0;

    function automatic void chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    // Monitor: ripple-counter model plus per-request observation, checked when done pulses.
    int cyc = 0, start = 0, rst_lo = 0, pulses = 0, cnt = 0;
    bit busy = 0, ena_bad = 0, prev_inc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy = 0;
            cnt = 0;
            prev_inc = 0;
        end else begin
            if (!ctrl_sel_rst_n) cnt = 0;
            else if (ctrl_sel_inc && !prev_inc) cnt = (cnt + 1) % CNT_MOD;
            if (busy) begin
                if (!ctrl_sel_rst_n) rst_lo++;
                if (ctrl_sel_inc && !prev_inc) pulses++;
                if (ctrl_ena && !bus.done) ena_bad = 1;
            end
            prev_inc = ctrl_sel_inc;
            if (bus.done) begin
                if (q.size() == 0 || !busy) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc - start, e.lat);
                    chk("cur_sel", int'(bus.cur_sel), e.addr);
                    chk("ripple_cnt", cnt, e.addr);
                    chk("ctrl_ena_done", int'(ctrl_ena), e.ena);
                    chk("rst_low_cycles", rst_lo, e.rst_lo);
                    chk("inc_pulses", pulses, e.pulses);
                    chk("ena_low_during_seq", int'(ena_bad), 0);
                end
                busy = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                busy = 1;
                start = cyc;
                rst_lo = 0;
                pulses = 0;
                ena_bad = 0;
            end
        end
    end

    task automatic issue(input int a, input bit e, input bit f);
        exp_t x;
        bit   rp;
        int   n;
        int   k;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = a[SEL_W-1:0];
        bus.req_ena   = e;
        bus.req_force = f;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k == 100) chk("ready_timeout", 0, 1);
        rp = f || (a < sh);
        n  = rp ? a : a - sh;
        x.addr   = a;
        x.ena    = int'(e);
        x.rst_lo = rp ? RST_CYC : 0;
        x.pulses = n;
        x.lat    = rp ? 1 + RST_CYC + INC_LO + n * (INC_HI + INC_LO) + SETTLE + 1
                      : 1 + n * (INC_HI + INC_LO) + SETTLE + 1;
        q.push_back(x);
        sh = a;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Waits for the scoreboard to drain while firing ignored requests, always including the DONE cycle.
    task automatic wait_done();
        int k;
        for (k = 0; k < 6000; k++) begin
            @(posedge clk);
            #1;
            if (!bus.req_ready && (bus.done || $urandom_range(0, 2) == 0)) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = SEL_W'($urandom);
                bus.req_ena   = 1'($urandom);
                bus.req_force = 1'($urandom);
            end else begin
                bus.req_valid = 1'b0;
            end
            if (q.size() == 0) break;
        end
        bus.req_valid = 1'b0;
        if (k == 6000) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int k;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_ena   = 1'b0;
        bus.req_force = 1'b0;

        #13;
        chk("rst_ctrl_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        chk("rst_ctrl_sel_inc", int'(ctrl_sel_inc), 0);
        chk("rst_ctrl_ena", int'(ctrl_ena), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_cur_sel", int'(bus.cur_sel), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", int'(bus.req_ready), 1);
        chk("idle_ctrl_sel_rst_n", int'(ctrl_sel_rst_n), 1);

        issue(3, 1'b1, 1'b1);    wait_done();
        issue(5, 1'b1, 1'b0);    wait_done();
        issue(5, 1'b1, 1'b0);    wait_done();
        issue(2, 1'b0, 1'b0);    wait_done();
        issue(7, 1'b1, 1'b1);    wait_done();

        issue(100, 1'b1, 1'b0);
        k = 0;
        while (!ctrl_sel_inc && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("reach_inc_hi", int'(ctrl_sel_inc), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_inc", int'(ctrl_sel_inc), 0);
        chk("midrst_sel_rst_n", int'(ctrl_sel_rst_n), 0);
        chk("midrst_ena", int'(ctrl_ena), 0);
        chk("midrst_cur_sel", int'(bus.cur_sel), 0);
        chk("midrst_ready", int'(bus.req_ready), 1);
        q.delete();
        sh = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(1, 1'b1, 1'b0);           wait_done();
        issue(CNT_MOD - 1, 1'b1, 1'b0); wait_done();
        issue(0, 1'b0, 1'b0);           wait_done();

        for (int i = 0; i < 30; i++) begin
            issue($urandom_range(0, 60), 1'($urandom), ($urandom_range(0, 3) == 0));
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
